// File: rtl/io_sum_pkg.sv
// io_sum_pkg: shared state encoding, io_in bit map and result width for io_sum_engine
package io_sum_pkg;
  typedef enum logic [2:0] {HOLD, WAIT_A, WAIT_B, CALC, SHOW} state_t;
  localparam int IO_W = 6;
  localparam int DATA_LSB = 0;
  localparam int DATA_W = 4;
  localparam int SEL_BIT = 4;
  localparam int STB_BIT = 5;
  localparam int SUM_W = 5;
endpackage

// File: rtl/io_sum_engine_sync.sv
// io_sync_edge: STAGES-deep synchronizer on d_i (sync_o) with per-bit rising-edge pulse (rise_o)
module io_sync_edge #(
  parameter int W = 6,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);
  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0] prev_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
endmodule

// File: rtl/io_sum_engine.sv
// io_sum_engine: adds two strobed 4-bit pad operands; io_in data/sel/strobe in, io_out/io_oeb sum to pads, sum_valid/err status
module io_sum_engine
  import io_sum_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 12500,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [IO_W-1:0]  io_in,
  output logic [SUM_W-1:0] io_out,
  output logic [SUM_W-1:0] io_oeb,
  output logic             sum_valid,
  output logic             err
);
  localparam int CW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  logic [IO_W-1:0] sync, rise;
  state_t state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, ev, sel, done, unused_ok;
  io_sync_edge #(.W(IO_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .d_i(io_in),
    .sync_o(sync),
    .rise_o(rise)
  );
  assign ev = rise[STB_BIT];
  assign sel = sync[SEL_BIT];
  assign data = sync[DATA_LSB +: DATA_W];
  assign unused_ok = ^{sync[STB_BIT], rise[SEL_BIT:0]};
  assign done = HOLDOFF_CYCLES == 0 || int'(cnt_q) == HOLDOFF_CYCLES - 1;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (state_q)
      HOLD: begin
        cnt_d = done ? cnt_q : cnt_q + 1'b1;
        state_d = done ? WAIT_A : HOLD;
      end
      WAIT_A: begin
        a_d = ev && !sel ? data : a_q;
        state_d = ev && !sel ? WAIT_B : WAIT_A;
        err_d = err_q | (ev & sel);
      end
      WAIT_B: begin
        a_d = ev && !sel ? data : a_q;
        b_d = ev && sel ? data : b_q;
        state_d = ev && sel ? CALC : WAIT_B;
      end
      CALC: begin
        sum_d = {1'b0, a_q} + {1'b0, b_q};
        state_d = SHOW;
        err_d = err_q | ev;
      end
      SHOW: begin
        a_d = ev && !sel ? data : a_q;
        state_d = ev && !sel ? WAIT_B : SHOW;
        err_d = err_q | (ev & sel);
      end
      default: state_d = HOLD;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= HOLD;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign io_out = sum_q;
  assign io_oeb = {SUM_W{state_q == HOLD}};
  assign sum_valid = state_q == SHOW;
  assign err = err_q;
endmodule

// File: tb/tb_io_sum_engine.sv
// tb_io_sum_engine: directed table-driven check of io_sum_engine with HOLDOFF_CYCLES=16
module tb_io_sum_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] io_in = '0;
  logic [4:0] io_out, io_oeb;
  logic sum_valid, err;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic sel;
    logic [3:0] data;
    logic [4:0] out;
    logic valid;
    logic err;
    string name;
  } vec_t;
  vec_t v[11];
  io_sum_engine #(.HOLDOFF_CYCLES(16), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .io_in(io_in),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .sum_valid(sum_valid),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic check_all(input string nm, input logic [4:0] out, input logic [4:0] oeb, input logic valid, input logic e);
    check({nm, " io_out"}, 8'(io_out), 8'(out));
    check({nm, " io_oeb"}, 8'(io_oeb), 8'(oeb));
    check({nm, " sum_valid"}, 8'(sum_valid), 8'(valid));
    check({nm, " err"}, 8'(err), 8'(e));
  endtask
  task automatic pulse(input logic sel, input logic [3:0] d);
    io_in = {1'b0, sel, d};
    repeat (2) @(negedge clk);
    io_in[5] = 1'b1;
    repeat (4) @(negedge clk);
    io_in[5] = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pulse(v[i].sel, v[i].data);
      check_all(v[i].name, v[i].out, 5'b00000, v[i].valid, v[i].err);
    end
  endtask
  initial begin
    v[0] = '{1'b0, 4'd3, 5'd0, 1'b0, 1'b0, "A=3"};
    v[1] = '{1'b0, 4'd5, 5'd7, 1'b0, 1'b0, "b2b A=5"};
    v[2] = '{1'b1, 4'd2, 5'd7, 1'b1, 1'b0, "b2b B=2"};
    v[3] = '{1'b0, 4'd9, 5'd7, 1'b0, 1'b0, "A=9"};
    v[4] = '{1'b0, 4'd15, 5'd7, 1'b0, 1'b0, "A=15 overwrite"};
    v[5] = '{1'b1, 4'd15, 5'd30, 1'b1, 1'b0, "B=15 max"};
    v[6] = '{1'b1, 4'd3, 5'd30, 1'b1, 1'b1, "B in SHOW"};
    v[7] = '{1'b0, 4'd6, 5'd30, 1'b0, 1'b1, "A=6 pre-reset"};
    v[8] = '{1'b1, 4'd1, 5'd0, 1'b0, 1'b1, "B in WAIT_A"};
    v[9] = '{1'b0, 4'd1, 5'd0, 1'b0, 1'b1, "A=1 after err"};
    v[10] = '{1'b1, 4'd2, 5'd3, 1'b1, 1'b1, "B=2 after err"};
    repeat (2) @(negedge clk);
    check_all("reset", 5'd0, 5'b11111, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) io_in = 6'b110101;
      if (i == 5) io_in = 6'b000000;
      @(negedge clk);
      check($sformatf("holdoff oeb c%0d", i), 8'(io_oeb), i < 16 ? 8'h1f : 8'h00);
    end
    check_all("after holdoff", 5'd0, 5'b00000, 1'b0, 1'b0);
    run(0, 0);
    io_in = {1'b0, 1'b1, 4'd4};
    repeat (2) @(negedge clk);
    io_in[5] = 1'b1;
    repeat (3) @(negedge clk);
    check("B=4 N+1 sum_valid", 8'(sum_valid), 8'd0);
    check("B=4 N+1 io_out", 8'(io_out), 8'd0);
    @(negedge clk);
    check("B=4 N+2 sum_valid", 8'(sum_valid), 8'd1);
    check("B=4 N+2 io_out", 8'(io_out), 8'd7);
    io_in[5] = 1'b0;
    repeat (3) @(negedge clk);
    run(1, 7);
    io_in = 6'b100000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all("mid reset", 5'd0, 5'b11111, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    io_in = '0;
    repeat (17) @(negedge clk);
    check_all("stb across reset", 5'd0, 5'b00000, 1'b0, 1'b0);
    run(8, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
